// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the 3x3 convolution operand interface.
//   NumTaps      - taps per window (3x3)
//   StateFill/StateRun/StateDrain - 2-bit window-generator state encodings
//   state_e      - typed enum built on those encodings
package conv_window_gen_pkg;

    localparam int unsigned NumTaps = 9;

    localparam logic [1:0] StateFill  = 2'd0;
    localparam logic [1:0] StateRun   = 2'd1;
    localparam logic [1:0] StateDrain = 2'd2;

    typedef enum logic [1:0] {
        StFill  = StateFill,
        StRun   = StateRun,
        StDrain = StateDrain
    } state_e;

endpackage

// File: rtl/conv_line_buf.sv
// One image row of pixel storage, indexed by column.
// Read is combinational from the current contents, write lands on the clock edge, so a read
// and write at the same index in one cycle returns the old value (read-before-write).
// Contents are not reset; they are always rewritten before being used.
// Ports:
//   clk        rising-edge clock
//   idx_i      column index for both read and write
//   wr_en_i    write strobe
//   wr_data_i  pixel to store
//   rd_data_o  pixel previously stored at idx_i
module conv_line_buf #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 28
) (
    input  logic                      clk,
    input  logic [$clog2(DEPTH)-1:0]  idx_i,
    input  logic                      wr_en_i,
    input  logic signed [WIDTH-1:0]   wr_data_i,
    output logic signed [WIDTH-1:0]   rd_data_o
);

    logic signed [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data_o = mem_q[idx_i];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: accepts a raster-order pixel stream, keeps the two previous
// rows in line buffers and emits every valid-mode 3x3 window as nine registered signed taps
// (a0 top-left .. a8 bottom-right, row-major).
// Optional feature macro: WIN_POS_EN adds win_row/win_col (window centre coordinate).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pix_in/pix_valid    input pixel stream; taken when pix_valid & pix_ready
//   pix_ready           !win_valid | win_ready (combinational)
//   win_valid/win_ready window handshake
//   a0_out..a8_out      window taps
//   win_row/win_col     (WIN_POS_EN only) centre of the current window
//   frame_done          one-cycle pulse after the last pixel of a frame is taken
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [WIDTH-1:0]   pix_in,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    output logic                      win_valid,
    input  logic                      win_ready,
    output logic signed [WIDTH-1:0]   a0_out,
    output logic signed [WIDTH-1:0]   a1_out,
    output logic signed [WIDTH-1:0]   a2_out,
    output logic signed [WIDTH-1:0]   a3_out,
    output logic signed [WIDTH-1:0]   a4_out,
    output logic signed [WIDTH-1:0]   a5_out,
    output logic signed [WIDTH-1:0]   a6_out,
    output logic signed [WIDTH-1:0]   a7_out,
    output logic signed [WIDTH-1:0]   a8_out,
`ifdef WIN_POS_EN
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic [$clog2(IMG_W)-1:0]  win_col,
`endif
    output logic                      frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ColTwo  = CW'(2);
    localparam logic [CW-1:0] ColOne  = CW'(1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
    localparam logic [RW-1:0] RowOne  = RW'(1);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    state_e        state_q;
    logic          win_valid_q;
    logic          frame_done_q;

    logic signed [WIDTH-1:0] taps_q   [NumTaps];
    logic signed [WIDTH-1:0] win_next [NumTaps];
    // Two most recent columns, [0] is the older one; inner index 0=top, 1=mid, 2=bottom.
    logic signed [WIDTH-1:0] hist_q   [2][3];
    logic signed [WIDTH-1:0] new_col  [3];
    logic signed [WIDTH-1:0] lb0_rd;
    logic signed [WIDTH-1:0] lb1_rd;

    logic accept;
    logic last_pix;
    logic hit;

`ifdef WIN_POS_EN
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;
    assign win_row = win_row_q;
    assign win_col = win_col_q;
`endif

    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign last_pix  = (row_q == RowLast) && (col_q == ColLast);
    // RUN covers exactly the accepts with row >= 2 (DRAIN accepts belong to the next frame).
    assign hit       = (state_q == StRun) && (col_q >= ColTwo);

    // lb0 holds the previous row, lb1 the row before that.
    conv_line_buf #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W)
    ) lb0 (
        .clk       (clk),
        .idx_i     (col_q),
        .wr_en_i   (accept),
        .wr_data_i (pix_in),
        .rd_data_o (lb0_rd)
    );

    conv_line_buf #(
        .WIDTH (WIDTH),
        .DEPTH (IMG_W)
    ) lb1 (
        .clk       (clk),
        .idx_i     (col_q),
        .wr_en_i   (accept),
        .wr_data_i (lb0_rd),
        .rd_data_o (lb1_rd)
    );

    always_comb begin
        new_col[0] = lb1_rd;
        new_col[1] = lb0_rd;
        new_col[2] = pix_in;
        for (int r = 0; r < 3; r++) begin
            win_next[r*3 + 0] = hist_q[0][r];
            win_next[r*3 + 1] = hist_q[1][r];
            win_next[r*3 + 2] = new_col[r];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= StFill;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < NumTaps; k++) begin
                taps_q[k] <= '0;
            end
            for (int c = 0; c < 2; c++) begin
                for (int r = 0; r < 3; r++) begin
                    hist_q[c][r] <= '0;
                end
            end
`ifdef WIN_POS_EN
            win_row_q    <= '0;
            win_col_q    <= '0;
`endif
        end else begin
            frame_done_q <= accept && last_pix;

            if (accept) begin
                hist_q[0] <= hist_q[1];
                hist_q[1] <= new_col;
                if (col_q == ColLast) begin
                    col_q <= '0;
                    row_q <= (row_q == RowLast) ? '0 : row_q + RowOne;
                end else begin
                    col_q <= col_q + ColOne;
                end
            end

            if (accept && hit) begin
                taps_q      <= win_next;
                win_valid_q <= 1'b1;
`ifdef WIN_POS_EN
                win_row_q   <= row_q - RowOne;
                win_col_q   <= col_q - ColOne;
`endif
            end else if (win_ready) begin
                win_valid_q <= 1'b0;
            end

            unique case (state_q)
                StFill: begin
                    if (accept && (col_q == ColLast) && (row_q == RowOne)) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (accept && last_pix) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (accept || (win_valid_q && win_ready)) begin
                        state_q <= StFill;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign a0_out     = taps_q[0];
    assign a1_out     = taps_q[1];
    assign a2_out     = taps_q[2];
    assign a3_out     = taps_q[3];
    assign a4_out     = taps_q[4];
    assign a5_out     = taps_q[5];
    assign a6_out     = taps_q[6];
    assign a7_out     = taps_q[7];
    assign a8_out     = taps_q[8];

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen (IMG_W=4, IMG_H=4, WIDTH=9).
// A frame-image model predicts every output cycle by cycle; a vector table checks the first
// and last windows of specific frames; a random phase exercises handshakes and reset.
module tb_conv_window_gen;

    localparam int W    = 9;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int NPIX = IW * IH;
    localparam int NVEC = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [W-1:0] pix_in = '0;
    logic pix_valid = 1'b0;
    logic win_ready = 1'b0;
    logic pix_ready, win_valid, frame_done;
    logic signed [W-1:0] a0_out, a1_out, a2_out, a3_out, a4_out, a5_out, a6_out, a7_out, a8_out;
`ifdef WIN_POS_EN
    logic [1:0] win_row, win_col;
`endif

    conv_window_gen #(
        .WIDTH (W),
        .IMG_W (IW),
        .IMG_H (IH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .a0_out     (a0_out),
        .a1_out     (a1_out),
        .a2_out     (a2_out),
        .a3_out     (a3_out),
        .a4_out     (a4_out),
        .a5_out     (a5_out),
        .a6_out     (a6_out),
        .a7_out     (a7_out),
        .a8_out     (a8_out),
`ifdef WIN_POS_EN
        .win_row    (win_row),
        .win_col    (win_col),
`endif
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic signed [W-1:0] dut_taps [9];
    assign dut_taps[0] = a0_out;
    assign dut_taps[1] = a1_out;
    assign dut_taps[2] = a2_out;
    assign dut_taps[3] = a3_out;
    assign dut_taps[4] = a4_out;
    assign dut_taps[5] = a5_out;
    assign dut_taps[6] = a6_out;
    assign dut_taps[7] = a7_out;
    assign dut_taps[8] = a8_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the frame as a 2-D image plus the expected registered outputs.
    logic signed [W-1:0] img [IH][IW];
    logic signed [W-1:0] m_taps [9];
    bit m_valid = 1'b0;
    bit m_fd    = 1'b0;
    int m_n     = 0;
    int m_wins  = 0;
    int m_wr    = 0;
    int m_wc    = 0;

    int cap[$];     // taps of every window the DUT hands over, 9 entries per window
    int fd_seen = 0;

    typedef struct {
        int             base;
        int             mode;       // 0: base+i, 1: extreme values at tap positions
        int             stall_at;   // window index held off for 3 cycles, -1 none
        logic [8:0][8:0] first;
        logic [8:0][8:0] last;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [8:0][8:0] w9(input int v0, input int v1, input int v2,
                                           input int v3, input int v4, input int v5,
                                           input int v6, input int v7, input int v8);
        logic [8:0][8:0] r;
        r[0] = 9'(v0); r[1] = 9'(v1); r[2] = 9'(v2);
        r[3] = 9'(v3); r[4] = 9'(v4); r[5] = 9'(v5);
        r[6] = 9'(v6); r[7] = 9'(v7); r[8] = 9'(v8);
        return r;
    endfunction

    function automatic logic signed [W-1:0] pixval(input int base, input int mode, input int i);
        if (mode == 1) begin
            if (i == 0 || i == 5) return W'(-256);
            if (i == 10 || i == 15) return W'(255);
            return W'(i);
        end
        return W'(base + i);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_fd    = 1'b0;
        m_n     = 0;
        m_wr    = 0;
        m_wc    = 0;
        for (int k = 0; k < 9; k++) m_taps[k] = '0;
    endtask

    // One clock: drive after the falling edge, predict, then compare just after the rising edge.
    task automatic cycle(input bit v, input logic signed [W-1:0] p, input bit wr, output bit acc);
        bit exp_ready;
        int r, c;
        @(negedge clk);
        pix_valid = v;
        pix_in    = p;
        win_ready = wr;
        #1;
        exp_ready = !m_valid || wr;
        chk("pix_ready", 32'(pix_ready), 32'(exp_ready));
        acc = v && exp_ready;
        if (win_valid === 1'b1 && wr) begin
            for (int j = 0; j < 9; j++) cap.push_back(int'(dut_taps[j]));
        end
        m_fd = 1'b0;
        if (acc) begin
            r = m_n / IW;
            c = m_n % IW;
            img[r][c] = p;
            if (r >= 2 && c >= 2) begin
                for (int k = 0; k < 9; k++) m_taps[k] = img[r - 2 + k / 3][c - 2 + k % 3];
                m_valid = 1'b1;
                m_wins++;
                m_wr = r - 1;
                m_wc = c - 1;
            end else begin
                m_valid = 1'b0;
            end
            if (m_n == NPIX - 1) m_fd = 1'b1;
            m_n = (m_n + 1) % NPIX;
        end else if (m_valid && wr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("win_valid", 32'(win_valid), 32'(m_valid));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("a%0d_out", k), 32'(dut_taps[k]), 32'(m_taps[k]));
        end
`ifdef WIN_POS_EN
        chk("win_row", 32'(win_row), 32'(m_wr));
        chk("win_col", 32'(win_col), 32'(m_wc));
`endif
        if (frame_done === 1'b1) fd_seen++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pix_valid = 1'b0;
        win_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rst win_valid", 32'(win_valid), 0);
        chk("rst frame_done", 32'(frame_done), 0);
        chk("rst pix_ready", 32'(pix_ready), 1);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("rst a%0d_out", k), 32'(dut_taps[k]), 0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic stream(input int base, input int mode, input int stall_at, input int npix);
        bit acc;
        bit wr;
        int tries;
        int stall_left = 3;
        int start_wins = m_wins;
        for (int i = 0; i < npix; i++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 20) begin
                wr = 1'b1;
                if (stall_at >= 0 && m_valid && m_wins == start_wins + stall_at + 1
                    && stall_left > 0) begin
                    wr = 1'b0;
                    stall_left--;
                end
                cycle(1'b1, pixval(base, mode, i), wr, acc);
                tries++;
            end
            chk($sformatf("pixel %0d accepted", i), 32'(acc), 1);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, acc);
    endtask

    task automatic check_window(input string tag, input int widx, input logic [8:0][8:0] exp);
        for (int k = 0; k < 9; k++) begin
            if (cap.size() >= (widx + 1) * 9) begin
                chk($sformatf("%s a%0d", tag, k), 32'(cap[widx * 9 + k]), 32'($signed(exp[k])));
            end else begin
                chk($sformatf("%s missing", tag), 32'(cap.size() / 9), 32'(widx + 1));
            end
        end
    endtask

    initial begin
        int start_w;
        bit acc;

        vecs[0] = '{0, 0, -1, w9(0, 1, 2, 4, 5, 6, 8, 9, 10), w9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
        vecs[1] = '{100, 0, 1, w9(100, 101, 102, 104, 105, 106, 108, 109, 110),
                    w9(105, 106, 107, 109, 110, 111, 113, 114, 115)};
        vecs[2] = '{0, 1, 0, w9(-256, 1, 2, 4, -256, 6, 8, 9, 255),
                    w9(-256, 6, 7, 9, 255, 11, 13, 14, 255)};

        do_reset();

        // Frames streamed back to back, then checked against the table.
        start_w = cap.size() / 9;
        fd_seen = 0;
        for (int v = 0; v < NVEC; v++) stream(vecs[v].base, vecs[v].mode, vecs[v].stall_at, NPIX);
        idle(3);
        chk("table window count", 32'(cap.size() / 9 - start_w), 32'(4 * NVEC));
        chk("table frame_done count", 32'(fd_seen), NVEC);
        for (int v = 0; v < NVEC; v++) begin
            check_window($sformatf("vec%0d first", v), start_w + 4 * v, vecs[v].first);
            check_window($sformatf("vec%0d last", v), start_w + 4 * v + 3, vecs[v].last);
        end

        // Reset in the middle of a frame: the next frame must look exactly like the first one.
        stream(50, 0, -1, 7);
        do_reset();
        start_w = cap.size() / 9;
        fd_seen = 0;
        stream(0, 0, -1, NPIX);
        idle(3);
        chk("post-reset window count", 32'(cap.size() / 9 - start_w), 4);
        chk("post-reset frame_done count", 32'(fd_seen), 1);
        check_window("post-reset first", start_w, vecs[0].first);
        check_window("post-reset last", start_w + 3, vecs[0].last);

        // Random traffic with random backpressure and one asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0, acc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
